// File: rtl/seq_left_shifter.sv
// Iterative left shifter: accepts an operand, shifts one bit per cycle, then holds the result until it is taken.
// Optional build macro ROTATE_EN turns the logical left shift into a left rotate.
module seq_left_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_cnt;
    logic             w_accept;
    logic             w_fill;

`ifdef ROTATE_EN
    assign w_fill = r_data[WIDTH-1];
`else
    assign w_fill = 1'b0;
`endif

    assign out = r_data;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = (ctrl == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                // Leaving on the edge that performs the last shift keeps the maximum count from wrapping.
                if (r_cnt == SHW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= in;
                r_cnt  <= ctrl;
            end else if (r_state == S_SHIFT) begin
                r_data <= {r_data[WIDTH-2:0], w_fill};
                r_cnt  <= r_cnt - SHW'(1);
            end
        end
    end

endmodule

// File: doc/seq_left_shifter.md
# seq_left_shifter

Iterative left shifter: the opposite-direction, clocked counterpart to the combinational right barrel shifter in the shifter library. It accepts an operand and a shift amount over a valid/ready handshake, then shifts left by one bit per cycle. It presents the result on a held output handshake. It is used where area matters more than latency, and where a shifted word must be moved back toward its original alignment.

## Interface
- WIDTH, 8, operand/result width in bits
- SHW, 3, shift-amount width; legal shift range 0..2^SHW-1 (must satisfy 2^SHW ≤ WIDTH)
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand and ctrl are valid
- in_ready  output  1  block can accept an operand (high only in IDLE)
- in  input  WIDTH  operand
- ctrl  input  SHW  left-shift amount
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  consumer takes result
- out  output  WIDTH  result
- busy  output  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE. Internal registers: data (WIDTH bits) and cnt (SHW bits).
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid && in_ready: data←in.
  - If ctrl==0: go to DONE.
  - Otherwise: cnt←ctrl and go to SHIFT.
  - in and ctrl are sampled only on the accept edge. Later changes are ignored.
- SHIFT:
  - Each edge: data←{data[WIDTH-2:0], fill} and cnt←cnt-1.
  - fill=0 (logical shift) unless ROTATE_EN is defined; see Configuration.
  - When cnt==1 on that edge: go to DONE.
- DONE:
  - out_valid=1 and out=data.
  - out is stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE. The next operand is accepted no earlier than the following cycle, because in_ready=0 in DONE.
- out is driven from the data register in all states. It is guaranteed meaningful only while out_valid=1.
- in_valid seen outside IDLE is ignored, not queued.
- Arithmetic is modulo WIDTH. Bits shifted past the MSB are discarded (or wrap, with ROTATE_EN).
- The maximum shift (2^SHW-1) completes without cnt wrap-around.

## Timing
- Reset: state=IDLE, data=0, cnt=0. out=0, out_valid=0, in_ready=1, busy=0, all visible on the cycle after the reset edge.
- rst asserted in any state, including mid-SHIFT or DONE with out_valid high, aborts the operation. The result is lost and the block returns to the reset values. rst takes priority over every handshake.
- Latency from accept edge to out_valid high:
  - ctrl≥1: ctrl+1 edges.
  - ctrl=0: 1 edge.
- Throughput: one operation per ctrl+2 cycles when out_ready is held high. The DONE→IDLE turnaround takes 1 cycle.
- Handshake rules:
  - in_valid is not required to wait for in_ready.
  - Transfer occurs only on a cycle where both signals are high.
  - The same rules apply to out_valid/out_ready.

## Configuration
- ROTATE_EN:
  - Defined: fill = data[WIDTH-1], so the block performs a left rotate.
  - Undefined (default): fill = 1'b0, so the block performs a logical left shift.
  - Ports, FSM and timing are identical in both builds.

## Test plan
- Reset, then in=8'd1, ctrl=4, out_ready=1 → out_valid high 5 cycles after accept, out=8'd16, then back to IDLE with in_ready=1.
- in=8'd255, ctrl=7 → out=8'd128 with a logical shift; out=8'd255 with ROTATE_EN. In both builds out_valid rises 8 cycles after accept.
- in=8'd128, ctrl=1 → out=8'd0 with a logical shift; out=8'd1 with ROTATE_EN. ctrl=0 with in=8'hA5 → out=8'hA5 with out_valid 1 cycle after accept.
- Backpressure: complete in=8'd3, ctrl=2 with out_ready=0 for 3 cycles → out_valid and out=8'd12 stay stable. During this, in_valid=1 with in=8'd7 is ignored (in_ready=0). Raising out_ready → IDLE next cycle.
- Reset mid-operation: accept in=8'd1, ctrl=6, then assert rst 3 cycles later → next cycle out=0, out_valid=0, in_ready=1, busy=0. A fresh op (in=8'd2, ctrl=2) then yields 8'd8.
